uart_rx_param: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver.
- Configurable baud, data width (5–9), parity mode, stop-bit count.
- Adds a 2-FF input synchroniser, 3-sample majority voting at mid-bit, and false-start rejection.
- Holds each received word for a valid/ready handshake and reports parity error, framing error, break and overrun.
- Sits between the board RX pin and the command-parser logic.

---
 rtl/uart_rx_param_if.sv | 21 ++
 rtl/uart_rx_param.sv | 158 +++++++++++++++
 tb/tb_uart_rx_param.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial line plus received-word handshake and status flags.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 uart_rx;
    logic [DATA_BITS-1:0] uart_rxdata;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_break;
    logic                 rx_overrun;
    modport master (
        input  uart_rx, rx_ready,
        output uart_rxdata, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun
    );
    modport slave (
        output uart_rx, rx_ready,
        input  uart_rxdata, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun
    );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-vote sampling, holding register and error flags.
module uart_rx_param #(
    parameter int BD_RATE   = 9600,
    parameter int RX_CLK    = 50_000_000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input logic clk,
    input logic rst,
    uart_rx_param_if.master bus
);
    localparam int CPB  = RX_CLK / BD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam logic [CW-1:0] C_LO  = CW'(HALF - 1);
    localparam logic [CW-1:0] C_MID = CW'(HALF);
    localparam logic [CW-1:0] C_HI  = CW'(HALF + 1);
    localparam logic [CW-1:0] C_END = CW'(CPB - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic                 r_sync1, r_rxs, r_rxs_q, r_s0, r_s1;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic                 r_pe, r_fe, r_stop0_low, r_par_vote, r_brk_latch;
    logic                 r_valid, r_perr, r_ferr, r_brk, r_ovr;

    logic w_vote, w_mid, w_end, w_last_stop, w_commit, w_ferr, w_stop0_low, w_break, w_accept, w_par_exp;

    assign w_vote      = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);
    assign w_mid       = r_cnt == C_HI;
    assign w_end       = r_cnt == C_END;
    assign w_last_stop = r_idx == 4'(STOP_BITS - 1);
    assign w_commit    = r_state == S_STOP && w_mid && w_last_stop;
    assign w_ferr      = r_fe | ~w_vote;
    assign w_stop0_low = r_idx == 4'd0 ? ~w_vote : r_stop0_low;
    assign w_break     = r_shift == '0 && (PARITY == 0 || !r_par_vote) && w_stop0_low;
    assign w_accept    = !r_valid || bus.rx_ready;
    assign w_par_exp   = (PARITY == 1) ? ~^r_shift : ^r_shift;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1     <= 1'b1;
            r_rxs       <= 1'b1;
            r_rxs_q     <= 1'b1;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_pe        <= 1'b0;
            r_fe        <= 1'b0;
            r_stop0_low <= 1'b0;
            r_par_vote  <= 1'b1;
            r_brk_latch <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_brk       <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_sync1 <= bus.uart_rx;
            r_rxs   <= r_sync1;
            r_rxs_q <= r_rxs;
            r_ovr   <= 1'b0;
            if (r_cnt == C_LO) r_s0 <= r_rxs;
            if (r_cnt == C_MID) r_s1 <= r_rxs;
            if (r_state != S_IDLE) r_cnt <= w_end ? '0 : r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    // after a break, wait for one full bit time of continuous idle before rearming
                    if (r_brk_latch) begin
                        r_cnt <= (!r_rxs || w_end) ? '0 : r_cnt + 1'b1;
                        if (r_rxs && w_end) r_brk_latch <= 1'b0;
                    end else if (r_rxs_q && !r_rxs) begin
                        r_state     <= S_START;
                        r_cnt       <= '0;
                        r_pe        <= 1'b0;
                        r_fe        <= 1'b0;
                        r_stop0_low <= 1'b0;
                        r_par_vote  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_mid && w_vote) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_end) begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_mid) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_end) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == 4'(DATA_BITS - 1)) begin
                            r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                            r_idx   <= '0;
                        end
                    end
                end
                S_PAR: begin
                    if (w_mid) begin
                        r_par_vote <= w_vote;
                        r_pe       <= w_vote != w_par_exp;
                    end
                    if (w_end) begin
                        r_state <= S_STOP;
                        r_idx   <= '0;
                    end
                end
                S_STOP: begin
                    if (w_end) r_idx <= r_idx + 1'b1;
                    if (w_mid) begin
                        if (r_idx == 4'd0) r_stop0_low <= ~w_vote;
                        if (!w_vote) r_fe <= 1'b1;
                        if (w_last_stop) begin
                            r_state     <= S_IDLE;
                            r_cnt       <= '0;
                            r_brk_latch <= w_break;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_commit && w_accept) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_perr  <= r_pe;
                r_ferr  <= w_ferr;
                r_brk   <= w_break;
            end else if (w_commit) begin
                r_ovr <= 1'b1;
            end else if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
                r_brk   <= 1'b0;
            end
        end
    end

    assign bus.uart_rxdata   = r_data;
    assign bus.rx_valid      = r_valid;
    assign bus.rx_parity_err = r_perr;
    assign bus.rx_frame_err  = r_ferr;
    assign bus.rx_break      = r_brk;
    assign bus.rx_overrun    = r_ovr;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of three receiver configurations at 16 clocks per bit.
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    int       rises[3];
    int       vcyc[3];
    int       ovrs[3];
    logic [8:0] cap_d[3];
    logic [2:0] cap_f[3];
    logic       pv[3];

    uart_rx_param_if #(.DATA_BITS(8)) if8 ();
    uart_rx_param_if #(.DATA_BITS(7)) if7 ();
    uart_rx_param_if #(.DATA_BITS(8)) if2 ();

    uart_rx_param #(.BD_RATE(10000), .RX_CLK(160000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u8n1 (.clk(clk), .rst(rst), .bus(if8));
    uart_rx_param #(.BD_RATE(10000), .RX_CLK(160000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
        u7e1 (.clk(clk), .rst(rst), .bus(if7));
    uart_rx_param #(.BD_RATE(10000), .RX_CLK(160000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
        u8n2 (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    task automatic mon(input int s, input logic v, input logic [8:0] d, input logic [2:0] f, input logic o);
        if (v && !pv[s]) begin
            rises[s]++;
            cap_d[s] = d;
            cap_f[s] = f;
        end
        if (v) vcyc[s]++;
        if (o) ovrs[s]++;
        pv[s] = v;
    endtask

    always @(negedge clk) begin
        mon(0, if8.rx_valid, {1'b0, if8.uart_rxdata}, {if8.rx_parity_err, if8.rx_frame_err, if8.rx_break}, if8.rx_overrun);
        mon(1, if7.rx_valid, {2'b0, if7.uart_rxdata}, {if7.rx_parity_err, if7.rx_frame_err, if7.rx_break}, if7.rx_overrun);
        mon(2, if2.rx_valid, {1'b0, if2.uart_rxdata}, {if2.rx_parity_err, if2.rx_frame_err, if2.rx_break}, if2.rx_overrun);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        for (int i = 0; i < 3; i++) begin
            rises[i] = 0;
            vcyc[i]  = 0;
            ovrs[i]  = 0;
        end
    endtask

    task automatic set_line(input int s, input logic v);
        case (s)
            0: if8.uart_rx = v;
            1: if7.uart_rx = v;
            default: if2.uart_rx = v;
        endcase
    endtask

    task automatic send(input int s, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(s, bits[i]);
            idle(16);
        end
        set_line(s, 1'b1);
    endtask

    task automatic test_reset();
        idle(3);
        checks++; if (if8.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b want 0", if8.rx_valid); end
        checks++; if (if8.uart_rxdata !== 8'h00) begin errors++; $display("FAIL reset_data8: got %h want 00", if8.uart_rxdata); end
        checks++; if ({if8.rx_parity_err, if8.rx_frame_err, if8.rx_break, if8.rx_overrun} !== 4'b0) begin errors++; $display("FAIL reset_flags8: got %b want 0000", {if8.rx_parity_err, if8.rx_frame_err, if8.rx_break, if8.rx_overrun}); end
        checks++; if (if7.rx_valid !== 1'b0 || if7.uart_rxdata !== 7'h00) begin errors++; $display("FAIL reset_7e1: got valid %b data %h want 0 00", if7.rx_valid, if7.uart_rxdata); end
        checks++; if (if2.rx_valid !== 1'b0 || if2.uart_rxdata !== 8'h00) begin errors++; $display("FAIL reset_8n2: got valid %b data %h want 0 00", if2.rx_valid, if2.uart_rxdata); end
        rst = 1'b1;
        idle(20);
    endtask

    task automatic test_8n1();
        clr();
        send(0, {6'b0, 1'b1, 8'h2A, 1'b0}, 10);
        idle(20);
        checks++; if (rises[0] !== 1) begin errors++; $display("FAIL 8n1_count: got %0d want 1", rises[0]); end
        checks++; if (vcyc[0] !== 1) begin errors++; $display("FAIL 8n1_valid_cycles: got %0d want 1", vcyc[0]); end
        checks++; if (cap_d[0] !== 9'h02A) begin errors++; $display("FAIL 8n1_data: got %h want 02a", cap_d[0]); end
        checks++; if (cap_f[0] !== 3'b000) begin errors++; $display("FAIL 8n1_flags: got %b want 000", cap_f[0]); end
        checks++; if (ovrs[0] !== 0) begin errors++; $display("FAIL 8n1_overrun: got %0d want 0", ovrs[0]); end
    endtask

    task automatic test_glitch();
        clr();
        set_line(0, 1'b0);
        idle(3);
        set_line(0, 1'b1);
        idle(40);
        checks++; if (rises[0] !== 0) begin errors++; $display("FAIL glitch_no_valid: got %0d want 0", rises[0]); end
        send(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
        idle(20);
        checks++; if (rises[0] !== 1 || cap_d[0] !== 9'h0C3) begin errors++; $display("FAIL glitch_then_frame: got %0d words data %h want 1 0c3", rises[0], cap_d[0]); end
    endtask

    task automatic test_parity();
        clr();
        send(1, {6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
        idle(20);
        checks++; if (cap_d[1] !== 9'h041) begin errors++; $display("FAIL par_bad_data: got %h want 041", cap_d[1]); end
        checks++; if (cap_f[1] !== 3'b100) begin errors++; $display("FAIL par_bad_flags: got %b want 100", cap_f[1]); end
        send(1, {6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
        idle(20);
        checks++; if (rises[1] !== 2 || cap_d[1] !== 9'h041) begin errors++; $display("FAIL par_good_data: got %0d words data %h want 2 041", rises[1], cap_d[1]); end
        checks++; if (cap_f[1] !== 3'b000) begin errors++; $display("FAIL par_good_flags: got %b want 000", cap_f[1]); end
    endtask

    task automatic test_overrun();
        clr();
        if8.rx_ready = 1'b0;
        send(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
        idle(20);
        checks++; if (if8.rx_valid !== 1'b1 || if8.uart_rxdata !== 8'h55) begin errors++; $display("FAIL ovr_first: got valid %b data %h want 1 55", if8.rx_valid, if8.uart_rxdata); end
        send(0, {6'b0, 1'b1, 8'hAA, 1'b0}, 10);
        idle(20);
        checks++; if (if8.uart_rxdata !== 8'h55) begin errors++; $display("FAIL ovr_hold: got %h want 55", if8.uart_rxdata); end
        checks++; if (ovrs[0] !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", ovrs[0]); end
        checks++; if (if8.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_still_valid: got %b want 1", if8.rx_valid); end
        if8.rx_ready = 1'b1;
        idle(1);
        checks++; if (if8.rx_valid !== 1'b0 || if8.uart_rxdata !== 8'h55) begin errors++; $display("FAIL ovr_drain: got valid %b data %h want 0 55", if8.rx_valid, if8.uart_rxdata); end
        idle(10);
    endtask

    task automatic test_break();
        clr();
        set_line(0, 1'b0);
        idle(320);
        set_line(0, 1'b1);
        idle(10);
        checks++; if (rises[0] !== 1 || cap_d[0] !== 9'h000) begin errors++; $display("FAIL brk_word: got %0d words data %h want 1 000", rises[0], cap_d[0]); end
        checks++; if (cap_f[0] !== 3'b011) begin errors++; $display("FAIL brk_flags: got %b want 011", cap_f[0]); end
        set_line(0, 1'b0);
        idle(30);
        set_line(0, 1'b1);
        idle(200);
        checks++; if (rises[0] !== 1) begin errors++; $display("FAIL brk_latch: got %0d words want 1", rises[0]); end
        send(0, {6'b0, 1'b1, 8'h2A, 1'b0}, 10);
        idle(20);
        checks++; if (rises[0] !== 2 || cap_d[0] !== 9'h02A) begin errors++; $display("FAIL brk_after_data: got %0d words data %h want 2 02a", rises[0], cap_d[0]); end
        checks++; if (cap_f[0] !== 3'b000) begin errors++; $display("FAIL brk_after_flags: got %b want 000", cap_f[0]); end
    endtask

    task automatic test_stop2();
        clr();
        send(2, {5'b0, 2'b11, 8'hF0, 1'b0}, 11);
        idle(20);
        checks++; if (cap_d[2] !== 9'h0F0 || cap_f[2] !== 3'b000) begin errors++; $display("FAIL stop2_good: got data %h flags %b want 0f0 000", cap_d[2], cap_f[2]); end
        send(2, {5'b0, 2'b01, 8'hF0, 1'b0}, 11);
        idle(20);
        checks++; if (rises[2] !== 2 || cap_d[2] !== 9'h0F0) begin errors++; $display("FAIL stop2_bad_data: got %0d words data %h want 2 0f0", rises[2], cap_d[2]); end
        checks++; if (cap_f[2] !== 3'b010) begin errors++; $display("FAIL stop2_bad_flags: got %b want 010", cap_f[2]); end
    endtask

    task automatic test_reset_mid();
        clr();
        send(2, {5'b0, 2'b11, 8'h3C, 1'b0}, 5);
        rst = 1'b0;
        idle(1);
        checks++; if (if2.rx_valid !== 1'b0 || if2.uart_rxdata !== 8'h00) begin errors++; $display("FAIL rstmid_outputs: got valid %b data %h want 0 00", if2.rx_valid, if2.uart_rxdata); end
        checks++; if ({if2.rx_parity_err, if2.rx_frame_err, if2.rx_break, if2.rx_overrun} !== 4'b0) begin errors++; $display("FAIL rstmid_flags: got %b want 0000", {if2.rx_parity_err, if2.rx_frame_err, if2.rx_break, if2.rx_overrun}); end
        rst = 1'b1;
        idle(240);
        checks++; if (rises[2] !== 0) begin errors++; $display("FAIL rstmid_no_commit: got %0d words want 0", rises[2]); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        clr();
        if8.uart_rx = 1'b1;
        if7.uart_rx = 1'b1;
        if2.uart_rx = 1'b1;
        if8.rx_ready = 1'b1;
        if7.rx_ready = 1'b1;
        if2.rx_ready = 1'b1;
        test_reset();
        test_8n1();
        test_glitch();
        test_parity();
        test_overrun();
        test_break();
        test_stop2();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
